// File: rtl/offchip_line_responder.sv
// rtl/offchip_line_responder.sv - row-to-beat serializing responder for the off-chip memory port
// Writes split a row into N_BEAT beats; reads reassemble returned beats into one row.
module offchip_line_responder #(
  parameter int W_A          = 32,
  parameter int W_OFF_D      = 128,
  parameter int W_PHY_D      = 32,
  parameter int W_PHY_OFFSET = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [W_A-1:0]     MEM_ADDR,
  input  logic [W_OFF_D-1:0] MEM_D,
  input  logic               MEM_WE,
  input  logic               MEM_RE,
  output logic [W_OFF_D-1:0] MEM_Q,
  output logic               MEM_RDY,
  output logic [W_A-1:0]     PHY_ADDR,
  output logic [W_PHY_D-1:0] PHY_WDATA,
  output logic               PHY_WE,
  output logic               PHY_RE,
  input  logic               PHY_ACK,
  input  logic               PHY_RVALID,
  input  logic [W_PHY_D-1:0] PHY_RDATA,
  output logic               ERR
);
  localparam int N_BEAT = W_OFF_D / W_PHY_D;
  localparam int CW     = $clog2(N_BEAT) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(N_BEAT - 1);
  localparam logic [CW-1:0] FULL_ROW  = CW'(N_BEAT);

  typedef enum logic [2:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, RESP} state_t;

  state_t             r_state, w_state_nxt;
  logic [W_A-1:0]     r_base, w_base_nxt;
  logic [W_OFF_D-1:0] r_row, w_row_nxt;
  logic [W_OFF_D-1:0] r_asm, w_asm_nxt;
  logic [CW-1:0]      r_iss_cnt, w_iss_nxt;
  logic [CW-1:0]      r_ret_cnt, w_ret_nxt;
  logic [W_OFF_D-1:0] r_mem_q, w_mem_q_nxt;
  logic               r_mem_rdy, w_rdy_nxt;
  logic [W_A-1:0]     r_phy_addr, w_addr_nxt;
  logic [W_PHY_D-1:0] r_phy_wdata, w_wdata_nxt;
  logic               r_phy_we, w_we_nxt;
  logic               r_phy_re, w_re_nxt;
  logic               r_err, w_err_nxt;

  logic               w_rd_phase;
  logic               w_ack_rd;
  logic [CW-1:0]      w_iss_inc;
  logic [CW-1:0]      w_iss_eff;
  logic [CW-1:0]      w_ret_inc;
  logic [W_A-1:0]     w_next_addr;

  assign w_rd_phase  = (r_state == RD_ISSUE) || (r_state == RD_WAIT);
  assign w_ack_rd    = (r_state == RD_ISSUE) && PHY_ACK;
  assign w_iss_inc   = r_iss_cnt + CW'(1);
  // A beat accepted this cycle may legally return in the same cycle.
  assign w_iss_eff   = r_iss_cnt + CW'(w_ack_rd);
  assign w_ret_inc   = r_ret_cnt + CW'(1);
  assign w_next_addr = r_base + (W_A'(w_iss_inc) << W_PHY_OFFSET);

  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    w_row_nxt   = r_row;
    w_asm_nxt   = r_asm;
    w_iss_nxt   = r_iss_cnt;
    w_ret_nxt   = r_ret_cnt;
    w_mem_q_nxt = r_mem_q;
    w_rdy_nxt   = 1'b0;
    w_addr_nxt  = r_phy_addr;
    w_wdata_nxt = r_phy_wdata;
    w_we_nxt    = r_phy_we;
    w_re_nxt    = r_phy_re;
    w_err_nxt   = r_err;

    if (PHY_RVALID && (!w_rd_phase || (r_ret_cnt >= w_iss_eff))) begin
      w_err_nxt = 1'b1;
    end

    case (r_state)
      IDLE: begin
        w_iss_nxt = '0;
        w_ret_nxt = '0;
        if (MEM_WE) begin
          if (MEM_RE) begin
            w_err_nxt = 1'b1;
          end
          w_base_nxt  = MEM_ADDR;
          w_row_nxt   = MEM_D;
          w_addr_nxt  = MEM_ADDR;
          w_wdata_nxt = MEM_D[W_PHY_D-1:0];
          w_we_nxt    = 1'b1;
          w_state_nxt = WR_ISSUE;
        end else if (MEM_RE) begin
          w_base_nxt  = MEM_ADDR;
          w_addr_nxt  = MEM_ADDR;
          w_re_nxt    = 1'b1;
          w_state_nxt = RD_ISSUE;
        end
      end
      WR_ISSUE: begin
        if (PHY_ACK) begin
          w_iss_nxt = w_iss_inc;
          if (r_iss_cnt == LAST_BEAT) begin
            w_we_nxt    = 1'b0;
            w_rdy_nxt   = 1'b1;
            w_state_nxt = RESP;
          end else begin
            w_addr_nxt = w_next_addr;
            for (int k = 0; k < N_BEAT; k++) begin
              if (CW'(k) == w_iss_inc) begin
                w_wdata_nxt = r_row[k*W_PHY_D +: W_PHY_D];
              end
            end
          end
        end
      end
      RD_ISSUE: begin
        if (PHY_ACK) begin
          w_iss_nxt = w_iss_inc;
          if (r_iss_cnt == LAST_BEAT) begin
            w_re_nxt    = 1'b0;
            w_state_nxt = RD_WAIT;
          end else begin
            w_addr_nxt = w_next_addr;
          end
        end
      end
      RD_WAIT: begin
      end
      RESP: begin
        w_iss_nxt   = '0;
        w_ret_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Return path overrides the issue path so a coincident final ACK/RVALID completes directly.
    if (PHY_RVALID && w_rd_phase && (r_ret_cnt < w_iss_eff)) begin
      for (int k = 0; k < N_BEAT; k++) begin
        if (CW'(k) == r_ret_cnt) begin
          w_asm_nxt[k*W_PHY_D +: W_PHY_D] = PHY_RDATA;
        end
      end
      w_ret_nxt = w_ret_inc;
      if (w_ret_inc == FULL_ROW) begin
        w_mem_q_nxt = w_asm_nxt;
        w_rdy_nxt   = 1'b1;
        w_re_nxt    = 1'b0;
        w_state_nxt = RESP;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_row       <= '0;
      r_asm       <= '0;
      r_iss_cnt   <= '0;
      r_ret_cnt   <= '0;
      r_mem_q     <= '0;
      r_mem_rdy   <= 1'b0;
      r_phy_addr  <= '0;
      r_phy_wdata <= '0;
      r_phy_we    <= 1'b0;
      r_phy_re    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_base      <= w_base_nxt;
      r_row       <= w_row_nxt;
      r_asm       <= w_asm_nxt;
      r_iss_cnt   <= w_iss_nxt;
      r_ret_cnt   <= w_ret_nxt;
      r_mem_q     <= w_mem_q_nxt;
      r_mem_rdy   <= w_rdy_nxt;
      r_phy_addr  <= w_addr_nxt;
      r_phy_wdata <= w_wdata_nxt;
      r_phy_we    <= w_we_nxt;
      r_phy_re    <= w_re_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign MEM_Q     = r_mem_q;
  assign MEM_RDY   = r_mem_rdy;
  assign PHY_ADDR  = r_phy_addr;
  assign PHY_WDATA = r_phy_wdata;
  assign PHY_WE    = r_phy_we;
  assign PHY_RE    = r_phy_re;
  assign ERR       = r_err;

endmodule

// File: doc/offchip_line_responder.md
Name: offchip_line_responder

Overview:
- Responder end of the cache-marshaller off-chip memory interface (MEM_ADDR/MEM_D/MEM_WE/MEM_RE/MEM_Q/MEM_RDY).
- Accepts full-row requests of W_OFF_D bits and serializes them into N_BEAT narrow beats on a physical memory port.
- Write: splits the row into beats. Read: reassembles returned beats into one row and answers with a single MEM_RDY pulse.
- Sits between the marshaller and the board memory controller.

Parameters:
W_A, 32, address width (byte address), shared by both sides
W_OFF_D, 128, row width on the marshaller side
W_PHY_D, 32, physical beat width; W_OFF_D must be an integer multiple
W_PHY_OFFSET, 2, log2(bytes per beat); beat k address = MEM_ADDR + (k << W_PHY_OFFSET)
N_BEAT (localparam), W_OFF_D/W_PHY_D, beats per row

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
MEM_ADDR  in  W_A  row base address, held stable while a request is pending
MEM_D  in  W_OFF_D  write row, held with MEM_WE
MEM_WE  in  1  write request (level)
MEM_RE  in  1  read request (level)
MEM_Q  out  W_OFF_D  read row, valid when MEM_RDY=1
MEM_RDY  out  1  one-cycle completion pulse
PHY_ADDR  out  W_A  beat address
PHY_WDATA  out  W_PHY_D  beat write data
PHY_WE  out  1  beat write command, held until PHY_ACK
PHY_RE  out  1  beat read command, held until PHY_ACK
PHY_ACK  in  1  command accepted this cycle
PHY_RVALID  in  1  read beat returned (in issue order)
PHY_RDATA  in  W_PHY_D  read beat data
ERR  out  1  sticky protocol error flag

Behaviour:
- Reset (RST_N=0, async): state=IDLE; MEM_RDY, PHY_WE, PHY_RE, ERR=0; MEM_Q, PHY_ADDR, PHY_WDATA=0; both beat counters=0. Reset mid-operation aborts the transfer; any in-flight PHY beats are neither awaited nor counted.
- All outputs are registered.
- States: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, RESP.
- IDLE: the only state that samples MEM_WE/MEM_RE. MEM_WE=1 has priority over MEM_RE.
  - Write request: latch MEM_ADDR and MEM_D; drive PHY_ADDR=base, PHY_WDATA=beat 0, PHY_WE=1; go to WR_ISSUE.
  - Read request (RE only): latch base; PHY_ADDR=base, PHY_RE=1; go to RD_ISSUE.
- Beat ordering: beat k = MEM_D[(k+1)*W_PHY_D-1 : k*W_PHY_D]; beat 0 is the LSB lane at the lowest address.
- WR_ISSUE: on PHY_ACK, increment issue counter.
  - If that was beat N_BEAT-1: PHY_WE=0, MEM_RDY=1, go to RESP.
  - Otherwise present the next beat's address and data the following cycle, with PHY_WE still 1 (back-to-back; one beat per cycle maximum).
- RD_ISSUE: same issue stepping with PHY_RE. After the last ACK: PHY_RE=0, go to RD_WAIT.
- Return counter runs in RD_ISSUE and RD_WAIT, independent of the issue counter. Each PHY_RVALID writes PHY_RDATA into lane ret_cnt of the assembly register, then increments ret_cnt.
- Read completion: when the N_BEAT-th beat returns, MEM_Q = full assembled row (updated the same edge) and MEM_RDY=1; go to RESP. This can happen from RD_ISSUE if the final ACK and final RVALID coincide.
- RESP: MEM_RDY=1 for exactly this cycle, then IDLE with MEM_RDY=0. Requests are not sampled in RESP, because the requester drops RE/WE on the same edge it sees MEM_RDY.
- Minimum latency with ACK tied high and RVALID one cycle after ACK:
  - Write: N_BEAT+1 cycles from request to MEM_RDY.
  - Read: N_BEAT+2 cycles from request to MEM_RDY.
- MEM_Q holds the last read row. Writes do not change MEM_Q.
- ERR is set (sticky until reset) on any of:
  - PHY_RVALID outside RD_ISSUE/RD_WAIT;
  - ret_cnt exceeding the issued beat count;
  - MEM_WE and MEM_RE both sampled high in IDLE (the write still proceeds).
- Counter width: clog2(N_BEAT)+1 bits; counters clear on entry to IDLE.
- Address arithmetic is modulo 2^W_A (wrap-around, no error).

Test Plan:
- Write (W_OFF_D=128, W_PHY_D=32), MEM_ADDR=0x100, MEM_D=0x4444_4444_3333_3333_2222_2222_1111_1111, PHY_ACK tied 1 -> PHY writes (0x100,0x11111111), (0x104,0x22222222), (0x108,0x33333333), (0x10C,0x44444444) on consecutive cycles; MEM_RDY single pulse 5 cycles after request; MEM_Q unchanged.
- Read 0x200, memory returns beats 0xA0,0xA1,0xA2,0xA3 with PHY_ACK stalled 2 cycles per beat and RVALID 3 cycles later -> MEM_Q=0x000000A3_000000A2_000000A1_000000A0 exactly when MEM_RDY=1; PHY_ADDR steps 0x200..0x20C.
- Marshaller-style sequence: write 0x100, then RE asserted the edge after RDY for 0x300 -> exactly one write burst then one read burst, no duplicate request; MEM_RDY pulses twice total.
- RST_N pulsed low during beat 2 of a read -> PHY_RE and MEM_RDY drop asynchronously, state IDLE; a subsequent read of 0x400 completes correctly with fresh counters.
- PHY_RVALID injected while IDLE -> ERR=1 and stays 1; MEM_Q unchanged; next transfer still completes.
- MEM_WE and MEM_RE both high at 0x500 -> write burst only, ERR=1.
